// File: rtl/mdio_arbiter_master_if.sv
// Management-port bundle of the two-requester Clause-22 MDIO master:
// requester command/handshake signals plus the MDC/MDIO pad signals.
interface mdio_arbiter_master_if;
   logic        req0;
   logic        req1;
   logic        op0;
   logic        op1;
   logic [4:0]  phy0;
   logic [4:0]  phy1;
   logic [4:0]  reg0;
   logic [4:0]  reg1;
   logic [15:0] wdat0;
   logic [15:0] wdat1;
   logic [1:0]  gnt;
   logic        done;
   logic        done_id;
   logic [15:0] rdata;
   logic        busy;
   logic        mdc;
   logic        mdio_o;
   logic        mdio_oe;
   logic        mdio_i;

   modport master (
      input  req0, req1, op0, op1, phy0, phy1, reg0, reg1, wdat0, wdat1, mdio_i,
      output gnt, done, done_id, rdata, busy, mdc, mdio_o, mdio_oe
   );

   modport slave (
      output req0, req1, op0, op1, phy0, phy1, reg0, reg1, wdat0, wdat1, mdio_i,
      input  gnt, done, done_id, rdata, busy, mdc, mdio_o, mdio_oe
   );
endinterface

// File: rtl/mdio_arbiter_master.sv
// Clause-22 MDIO master shared by two requesters with round-robin arbitration.
// Generates MDC, serializes preamble + 32-bit frame, captures read data and
// reports per-requester completion. All bus updates happen on MDC falling ticks.
module mdio_arbiter_master #(
   parameter int CLK_DIV = 64,
   parameter int PRE_LEN = 32
) (
   input  logic clk,
   input  logic rst,
   mdio_arbiter_master_if.master bus
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [5:0] PRE_LAST = 6'((PRE_LEN > 0) ? (PRE_LEN - 1) : 0);
   localparam logic [5:0] BIT_LAST = 6'd31;
   localparam logic [5:0] TA_IDX   = 6'd14;
   localparam logic [5:0] DATA_IDX = 6'd16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_FRAME = 2'd2,
      ST_END   = 2'd3
   } state_t;

   // Frame word MSB first. On reads TA/DATA are released, so the bits are don't-care.
   function automatic logic [31:0] build_frame(input logic op, input logic [4:0] phy,
                                               input logic [4:0] regad, input logic [15:0] wdat);
      logic [31:0] w;
      if (op) begin
         w = {2'b01, 2'b10, phy, regad, 2'b11, 16'hFFFF};
      end else begin
         w = {2'b01, 2'b01, phy, regad, 2'b10, wdat};
      end
      return w;
   endfunction

   state_t            state_q,   state_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic              mdc_q,     mdc_d;
   logic [5:0]        bit_q,     bit_d;
   logic [31:0]       frame_q,   frame_d;
   logic              op_q,      op_d;
   logic              owner_q,   owner_d;
   logic              ptr_q,     ptr_d;
   logic [15:0]       rx_q,      rx_d;
   logic [15:0]       rdata_q,   rdata_d;
   logic              done_q,    done_d;
   logic              done_id_q, done_id_d;
   logic [1:0]        gnt_q,     gnt_d;
   logic              busy_q,    busy_d;
   logic              mdio_o_q,  mdio_o_d;
   logic              mdio_oe_q, mdio_oe_d;

   logic              tick_s;
   logic              fall_s;
   logic              rise_s;
   logic              req_any_s;
   logic              win_s;
   logic              win_op_s;
   logic [4:0]        win_phy_s;
   logic [4:0]        win_reg_s;
   logic [15:0]       win_wdat_s;
   logic [31:0]       win_frame_s;
   logic              launch_s;
   logic [5:0]        bit_nxt_s;

   assign tick_s      = (cnt_q == CNT_LAST);
   assign fall_s      = tick_s & mdc_q;
   assign rise_s      = tick_s & ~mdc_q;
   assign req_any_s   = bus.req0 | bus.req1;
   // Both pending: pointer decides; otherwise the single requester wins.
   assign win_s       = (bus.req0 & bus.req1) ? ptr_q : bus.req1;
   assign win_op_s    = win_s ? bus.op1   : bus.op0;
   assign win_phy_s   = win_s ? bus.phy1  : bus.phy0;
   assign win_reg_s   = win_s ? bus.reg1  : bus.reg0;
   assign win_wdat_s  = win_s ? bus.wdat1 : bus.wdat0;
   assign win_frame_s = build_frame(win_op_s, win_phy_s, win_reg_s, win_wdat_s);
   assign bit_nxt_s   = bit_q + 6'd1;

   // Next-state logic: MDC divider, frame sequencer, read capture and arbitration.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mdc_d     = mdc_q;
      bit_d     = bit_q;
      frame_d   = frame_q;
      op_d      = op_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      rx_d      = rx_q;
      rdata_d   = rdata_q;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      gnt_d     = 2'b00;
      busy_d    = busy_q;
      mdio_o_d  = mdio_o_q;
      mdio_oe_d = mdio_oe_q;
      launch_s  = 1'b0;

      if (tick_s) begin
         cnt_d = '0;
         mdc_d = ~mdc_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
         mdc_d = mdc_q;
      end

      // Read data is sampled mid-bit, MSB first.
      if (rise_s && (state_q == ST_FRAME) && op_q && (bit_q >= DATA_IDX)) begin
         rx_d = {rx_q[14:0], bus.mdio_i};
      end else begin
         rx_d = rx_q;
      end

      if (fall_s) begin
         case (state_q)
            ST_IDLE: begin
               if (req_any_s) begin
                  launch_s = 1'b1;
               end else begin
                  launch_s = 1'b0;
               end
            end
            ST_PRE: begin
               if (bit_q == PRE_LAST) begin
                  state_d   = ST_FRAME;
                  bit_d     = 6'd0;
                  mdio_o_d  = frame_q[31];
                  mdio_oe_d = 1'b1;
                  frame_d   = {frame_q[30:0], 1'b0};
               end else begin
                  bit_d = bit_nxt_s;
               end
            end
            ST_FRAME: begin
               if (bit_q == BIT_LAST) begin
                  state_d   = ST_END;
                  mdio_o_d  = 1'b1;
                  mdio_oe_d = 1'b0;
               end else begin
                  bit_d     = bit_nxt_s;
                  mdio_o_d  = frame_q[31];
                  frame_d   = {frame_q[30:0], 1'b0};
                  // Reads release the bus from the first TA bit onward.
                  mdio_oe_d = ~(op_q & (bit_nxt_s >= TA_IDX));
               end
            end
            ST_END: begin
               done_d    = 1'b1;
               done_id_d = owner_q;
               busy_d    = 1'b0;
               state_d   = ST_IDLE;
               mdio_o_d  = 1'b1;
               mdio_oe_d = 1'b0;
               if (op_q) begin
                  rdata_d = rx_q;
               end else begin
                  rdata_d = rdata_q;
               end
               if (req_any_s) begin
                  launch_s = 1'b1;
               end else begin
                  launch_s = 1'b0;
               end
            end
            default: begin
               state_d   = ST_IDLE;
               busy_d    = 1'b0;
               mdio_o_d  = 1'b1;
               mdio_oe_d = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // A grant overrides the idle values set above (back-to-back frames).
      if (launch_s) begin
         gnt_d   = win_s ? 2'b10 : 2'b01;
         ptr_d   = ~win_s;
         owner_d = win_s;
         op_d    = win_op_s;
         busy_d  = 1'b1;
         bit_d   = 6'd0;
         rx_d    = 16'h0000;
         mdio_oe_d = 1'b1;
         if (PRE_LEN == 0) begin
            state_d  = ST_FRAME;
            mdio_o_d = win_frame_s[31];
            frame_d  = {win_frame_s[30:0], 1'b0};
         end else begin
            state_d  = ST_PRE;
            mdio_o_d = 1'b1;
            frame_d  = win_frame_s;
         end
      end else begin
         gnt_d = 2'b00;
      end
   end

   // State and output registers; reset abandons any frame and releases the bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         mdc_q     <= 1'b0;
         bit_q     <= 6'd0;
         frame_q   <= 32'h0000_0000;
         op_q      <= 1'b0;
         owner_q   <= 1'b0;
         ptr_q     <= 1'b0;
         rx_q      <= 16'h0000;
         rdata_q   <= 16'h0000;
         done_q    <= 1'b0;
         done_id_q <= 1'b0;
         gnt_q     <= 2'b00;
         busy_q    <= 1'b0;
         mdio_o_q  <= 1'b1;
         mdio_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mdc_q     <= mdc_d;
         bit_q     <= bit_d;
         frame_q   <= frame_d;
         op_q      <= op_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         rx_q      <= rx_d;
         rdata_q   <= rdata_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         mdio_o_q  <= mdio_o_d;
         mdio_oe_q <= mdio_oe_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.rdata   = rdata_q;
   assign bus.busy    = busy_q;
   assign bus.mdc     = mdc_q;
   assign bus.mdio_o  = mdio_o_q;
   assign bus.mdio_oe = mdio_oe_q;

endmodule

// File: tb/tb_mdio_arbiter_master.sv
// Bench for mdio_arbiter_master: three instances (CLK_DIV=2/PRE=32,
// CLK_DIV=2/PRE=0, CLK_DIV=64/PRE=32) with a PHY model and frame reference model.
module tb_mdio_arbiter_master;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mdio_arbiter_master_if ifa ();
   mdio_arbiter_master_if ifb ();
   mdio_arbiter_master_if ifc ();

   mdio_arbiter_master #(.CLK_DIV(2),  .PRE_LEN(32)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   mdio_arbiter_master #(.CLK_DIV(2),  .PRE_LEN(0))  dut_b (.clk(clk), .rst(rst), .bus(ifb));
   mdio_arbiter_master #(.CLK_DIV(64), .PRE_LEN(32)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   int          sel = 0;
   logic [1:0]  t_req = 2'b00;
   logic        t_op   [2];
   logic [4:0]  t_phy  [2];
   logic [4:0]  t_reg  [2];
   logic [15:0] t_wdat [2];
   logic        t_mdio_i = 1'b1;

   assign ifa.req0 = t_req[0] & (sel == 0);
   assign ifa.req1 = t_req[1] & (sel == 0);
   assign ifb.req0 = t_req[0] & (sel == 1);
   assign ifb.req1 = t_req[1] & (sel == 1);
   assign ifc.req0 = t_req[0] & (sel == 2);
   assign ifc.req1 = t_req[1] & (sel == 2);
   assign ifa.op0 = t_op[0];   assign ifa.op1 = t_op[1];
   assign ifb.op0 = t_op[0];   assign ifb.op1 = t_op[1];
   assign ifc.op0 = t_op[0];   assign ifc.op1 = t_op[1];
   assign ifa.phy0 = t_phy[0]; assign ifa.phy1 = t_phy[1];
   assign ifb.phy0 = t_phy[0]; assign ifb.phy1 = t_phy[1];
   assign ifc.phy0 = t_phy[0]; assign ifc.phy1 = t_phy[1];
   assign ifa.reg0 = t_reg[0]; assign ifa.reg1 = t_reg[1];
   assign ifb.reg0 = t_reg[0]; assign ifb.reg1 = t_reg[1];
   assign ifc.reg0 = t_reg[0]; assign ifc.reg1 = t_reg[1];
   assign ifa.wdat0 = t_wdat[0]; assign ifa.wdat1 = t_wdat[1];
   assign ifb.wdat0 = t_wdat[0]; assign ifb.wdat1 = t_wdat[1];
   assign ifc.wdat0 = t_wdat[0]; assign ifc.wdat1 = t_wdat[1];
   assign ifa.mdio_i = t_mdio_i;
   assign ifb.mdio_i = t_mdio_i;
   assign ifc.mdio_i = t_mdio_i;

   // Observed instance, chosen by sel.
   logic [1:0]  m_gnt;
   logic        m_done, m_done_id, m_busy, m_mdc, m_o, m_oe;
   logic [15:0] m_rdata;
   always_comb begin
      case (sel)
         1: begin m_gnt = ifb.gnt; m_done = ifb.done; m_done_id = ifb.done_id; m_busy = ifb.busy;
                  m_mdc = ifb.mdc; m_o = ifb.mdio_o; m_oe = ifb.mdio_oe; m_rdata = ifb.rdata; end
         2: begin m_gnt = ifc.gnt; m_done = ifc.done; m_done_id = ifc.done_id; m_busy = ifc.busy;
                  m_mdc = ifc.mdc; m_o = ifc.mdio_o; m_oe = ifc.mdio_oe; m_rdata = ifc.rdata; end
         default: begin m_gnt = ifa.gnt; m_done = ifa.done; m_done_id = ifa.done_id; m_busy = ifa.busy;
                  m_mdc = ifa.mdc; m_o = ifa.mdio_o; m_oe = ifa.mdio_oe; m_rdata = ifa.rdata; end
      endcase
   end

   int n_vec = 0;
   int n_err = 0;
   logic        ptr_m = 1'b0;
   logic [15:0] last_rd [3] = '{16'h0, 16'h0, 16'h0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // mdio_o may only change in a cycle where mdc falls (reset excluded).
   int         viol = 0;
   logic [2:0] pv_mdc = 3'b000;
   logic [2:0] pv_o   = 3'b111;
   logic       pv_rst = 1'b1;
   always @(negedge clk) begin
      if (!rst && !pv_rst) begin
         if (ifa.mdio_o != pv_o[0] && !(pv_mdc[0] && !ifa.mdc)) viol++;
         if (ifb.mdio_o != pv_o[1] && !(pv_mdc[1] && !ifb.mdc)) viol++;
         if (ifc.mdio_o != pv_o[2] && !(pv_mdc[2] && !ifc.mdc)) viol++;
      end
      pv_mdc <= {ifc.mdc, ifb.mdc, ifa.mdc};
      pv_o   <= {ifc.mdio_o, ifb.mdio_o, ifa.mdio_o};
      pv_rst <= rst;
   end

   function automatic int cdiv(input int s);
      return (s == 2) ? 64 : 2;
   endfunction

   function automatic int plen(input int s);
      return (s == 1) ? 0 : 32;
   endfunction

   // PHY model: drives read data during DATA bits, idles high otherwise.
   function automatic logic phy_bit(input int f, input int pl, input logic op, input logic [15:0] rd);
      int k;
      k = f - pl;
      if (op && k >= 16 && k <= 31) return rd[31-k];
      return 1'b1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ptr_m = 1'b0;
      last_rd = '{16'h0, 16'h0, 16'h0};
   endtask

   // One frame from a single requester; abort_at >= 0 asserts rst in that DATA bit.
   task automatic run_frame(input int s, input logic id, input logic op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] rd,
                            input logic [15:0] exp_rd, input int abort_at);
      int cd, pl, f, nb, lat, be, oe_err, cnt;
      logic pm, got, dseen;
      bit eb[$], ee[$], ec[$];
      logic cap_o [72];
      logic cap_e [72];
      cd = cdiv(s);
      pl = plen(s);
      for (int i = 0; i < pl; i++) begin eb.push_back(1); ee.push_back(1); ec.push_back(1); end
      eb.push_back(0); eb.push_back(1);
      if (op) begin eb.push_back(1); eb.push_back(0); end
      else    begin eb.push_back(0); eb.push_back(1); end
      for (int i = 4; i >= 0; i--) eb.push_back(phy[i]);
      for (int i = 4; i >= 0; i--) eb.push_back(ra[i]);
      for (int i = 0; i < 14; i++) begin ee.push_back(1); ec.push_back(1); end
      if (!op) begin
         eb.push_back(1); eb.push_back(0);
         for (int i = 15; i >= 0; i--) eb.push_back(wd[i]);
      end
      for (int i = 0; i < 18; i++) begin ee.push_back(!op); ec.push_back(!op); end
      ee.push_back(0); ec.push_back(0);
      for (int i = 0; i < 72; i++) begin cap_o[i] = 1'bx; cap_e[i] = 1'bx; end

      @(negedge clk);
      sel = s;
      t_op[id] = op; t_phy[id] = phy; t_reg[id] = ra; t_wdat[id] = wd;
      t_op[!id] = 1'($urandom); t_phy[!id] = 5'($urandom);
      t_reg[!id] = 5'($urandom); t_wdat[!id] = 16'($urandom);
      t_req[id] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 2*cd + 4 && !got; c++) begin
         @(negedge clk);
         if (m_gnt != 2'b00) got = 1'b1;
      end
      check("gnt", 32'(m_gnt), 32'(id ? 2'b10 : 2'b01));
      t_req[id] = 1'b0;
      if (!got) return;
      check("busy_on", 32'(m_busy), 32'd1);
      t_op[id] = 1'($urandom); t_phy[id] = 5'($urandom);
      t_reg[id] = 5'($urandom); t_wdat[id] = 16'($urandom);
      if (s == 0) ptr_m = !id;
      f = 0; nb = 0; lat = 0; pm = 1'b0; dseen = 1'b0;
      t_mdio_i = phy_bit(0, pl, op, rd);
      for (int c = 1; c <= (pl + 33)*2*cd + 8 && !dseen; c++) begin
         @(negedge clk);
         if (pm && !m_mdc) begin
            f++;
            t_mdio_i = phy_bit(f, pl, op, rd);
            if (abort_at >= 0 && f == pl + 16 + abort_at) begin
               rst = 1'b1;
               #1;
               check("rst_out", {8'h0, m_mdc, m_o, m_oe, m_gnt, m_done, m_done_id, m_rdata, m_busy},
                     {8'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0});
               cnt = 0;
               repeat (4) begin @(negedge clk); if (m_done || m_busy || m_oe) cnt++; end
               rst = 1'b0;
               t_mdio_i = 1'b1;
               repeat (4) begin @(negedge clk); if (m_done || m_busy || m_oe) cnt++; end
               check("rst_quiet", 32'(cnt), 32'd0);
               ptr_m = 1'b0;
               last_rd = '{16'h0, 16'h0, 16'h0};
               return;
            end
         end
         if (!pm && m_mdc) begin
            if (f < 72) begin cap_o[f] = m_o; cap_e[f] = m_oe; end
            nb++;
         end
         pm = m_mdc;
         if (m_done) begin dseen = 1'b1; lat = c; end
      end
      t_mdio_i = 1'b1;
      check("done", 32'(dseen), 32'd1);
      if (!dseen) return;
      check("latency", 32'(lat), 32'((pl + 33)*2*cd));
      check("done_id", 32'(m_done_id), 32'(id));
      check("rdata", 32'(m_rdata), 32'(exp_rd));
      check("busy_off", 32'(m_busy), 32'd0);
      check("nbits", 32'(nb), 32'(pl + 33));
      be = 0; oe_err = 0;
      for (int i = 0; i < pl + 33; i++) begin
         if (ec[i] && cap_o[i] !== logic'(eb[i])) be++;
         if (cap_e[i] !== logic'(ee[i])) oe_err++;
      end
      check("bits", 32'(be), 32'd0);
      check("oe", 32'(oe_err), 32'd0);
      if (op) last_rd[s] = rd;
   endtask

   typedef struct {
      logic        id;
      logic        op;
      logic [4:0]  phy;
      logic [4:0]  ra;
      logic [15:0] wd;
      logic [15:0] rd;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t vt [6];

   initial begin
      int hi, lo, ng, nd, outs, w, raise_w, wexp;
      logic pend;
      int seq [4];
      logic id, op;
      logic [15:0] rd, erd;

      vt[0] = '{1'b0, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 16'h0000};
      vt[1] = '{1'b1, 1'b1, 5'h03, 5'h02, 16'h0000, 16'hA5C3, 16'hA5C3};
      vt[2] = '{1'b0, 1'b0, 5'h1F, 5'h1F, 16'hFFFF, 16'h0000, 16'hA5C3};
      vt[3] = '{1'b1, 1'b0, 5'h00, 5'h00, 16'h0000, 16'h0000, 16'hA5C3};
      vt[4] = '{1'b0, 1'b1, 5'h1F, 5'h1F, 16'h0000, 16'h0001, 16'h0001};
      vt[5] = '{1'b1, 1'b1, 5'h00, 5'h1F, 16'h0000, 16'h8000, 16'h8000};
      seq = '{0, 1, 0, 1};
      for (int i = 0; i < 2; i++) begin
         t_op[i] = 1'b0; t_phy[i] = 5'h0; t_reg[i] = 5'h0; t_wdat[i] = 16'h0;
      end

      // Reset values on all instances while reset is held.
      repeat (3) @(negedge clk);
      check("rst_a", {8'h0, ifa.mdc, ifa.mdio_o, ifa.mdio_oe, ifa.gnt, ifa.done, ifa.done_id, ifa.rdata, ifa.busy},
            {8'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0});
      check("rst_b", {8'h0, ifb.mdc, ifb.mdio_o, ifb.mdio_oe, ifb.gnt, ifb.done, ifb.done_id, ifb.rdata, ifb.busy},
            {8'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0});
      check("rst_c", {8'h0, ifc.mdc, ifc.mdio_o, ifc.mdio_oe, ifc.gnt, ifc.done, ifc.done_id, ifc.rdata, ifc.busy},
            {8'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0});
      rst = 1'b0;

      // MDC period and duty on the CLK_DIV=64 instance.
      hi = 0; lo = 0;
      for (int c = 0; c < 200 && !ifc.mdc; c++) @(negedge clk);
      for (int c = 0; c < 200 && ifc.mdc; c++) begin @(negedge clk); hi++; end
      for (int c = 0; c < 200 && !ifc.mdc; c++) begin @(negedge clk); lo++; end
      check("mdc_high", 32'(hi), 32'd64);
      check("mdc_low", 32'(lo), 32'd64);
      check("mdc_period", 32'(hi + lo), 32'd128);

      // Directed vectors on CLK_DIV=2, PRE_LEN=32.
      for (int i = 0; i < 6; i++)
         run_frame(0, vt[i].id, vt[i].op, vt[i].phy, vt[i].ra, vt[i].wd, vt[i].rd, vt[i].exp_rd, -1);

      // Randomized frames against the reference model.
      for (int i = 0; i < 8; i++) begin
         id = 1'($urandom); op = 1'($urandom); rd = 16'($urandom);
         erd = op ? rd : last_rd[0];
         run_frame(0, id, op, 5'($urandom), 5'($urandom), 16'($urandom), rd, erd, -1);
      end

      // Contention: both requesting from reset; grants must alternate.
      do_reset();
      sel = 0;
      for (int i = 0; i < 2; i++) begin
         t_op[i] = 1'b0; t_phy[i] = 5'(i + 4); t_reg[i] = 5'(i + 9); t_wdat[i] = 16'($urandom);
      end
      t_req = 2'b11;
      ng = 0; nd = 0; outs = 0; pend = 1'b0; raise_w = 0;
      for (int c = 0; c < 5*65*4 && nd < 4; c++) begin
         @(negedge clk);
         if (pend) begin t_req[raise_w] = 1'b1; pend = 1'b0; end
         if (m_done) begin
            if (nd < 4) check("cont_done_id", 32'(m_done_id), 32'(seq[nd]));
            nd++; outs--;
         end
         if (m_gnt != 2'b00) begin
            check("cont_overlap", 32'(outs), 32'd0);
            wexp = (t_req[0] && t_req[1]) ? int'(ptr_m) : int'(t_req[1]);
            check("cont_gnt_model", 32'(m_gnt), 32'(wexp ? 2'b10 : 2'b01));
            if (ng < 4) check("cont_gnt_seq", 32'(m_gnt), 32'(seq[ng] ? 2'b10 : 2'b01));
            w = m_gnt[1] ? 1 : 0;
            ptr_m = (w == 0);
            t_req[w] = 1'b0;
            if (ng < 3) begin pend = 1'b1; raise_w = w; end
            else t_req = 2'b00;
            ng++; outs++;
         end
      end
      t_req = 2'b00;
      check("cont_grants", 32'(ng), 32'd4);
      check("cont_dones", 32'(nd), 32'd4);

      // Reset during DATA bit 8 of a read, then a normal frame.
      run_frame(0, 1'b1, 1'b1, 5'h03, 5'h02, 16'h0000, 16'hA5C3, 16'h0000, 8);
      run_frame(0, 1'b0, 1'b0, 5'h0A, 5'h11, 16'hBEEF, 16'h0000, 16'h0000, -1);
      run_frame(0, 1'b1, 1'b1, 5'h0B, 5'h12, 16'h0000, 16'h3C5A, 16'h3C5A, -1);

      // Preamble suppression.
      run_frame(1, 1'b0, 1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 16'h0000, -1);
      run_frame(1, 1'b1, 1'b1, 5'h07, 5'h1E, 16'h0000, 16'h5AA5, 16'h5AA5, -1);

      // Full frame at the slow divider.
      run_frame(2, 1'b1, 1'b0, 5'h15, 5'h0A, 16'hC0DE, 16'h0000, 16'h0000, -1);

      check("mdio_chg", 32'(viol), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mdio_arbiter_master.md
# mdio_arbiter_master

Clause-22 MDIO management master that builds and serializes complete write and read frames toward the PHY / PCS-PMA management port. It shares that single MDIO bus between two requesters, for example a power-up configuration sequencer on port 0 and a register-access bridge on port 1, using round-robin arbitration. It generates MDC, drives and releases MDIO, captures read data, and reports completion per requester.

## Interface
- CLK_DIV, 64: clk cycles per MDC half-period. Must be ≥2. 125 MHz / 128 gives MDC ≈ 0.98 MHz.
- PRE_LEN, 32: number of preamble '1' bits before each frame. Legal range 0..32; 0 means preamble suppression.
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from requester 0 / 1
- op0 / op1  in  1  0 = write, 1 = read
- phy0 / phy1  in  5  PHY address
- reg0 / reg1  in  5  register address
- wdat0 / wdat1  in  16  write data, ignored for reads
- gnt  out  2  one-hot grant pulse, one clk wide
- done  out  1  frame-complete pulse, one clk wide
- done_id  out  1  requester that owned the completed frame
- rdata  out  16  read data, valid from `done` until the next `done`
- busy  out  1  a frame is in progress
- mdc  out  1  MDIO clock
- mdio_o  out  1  MDIO output value
- mdio_oe  out  1  MDIO output enable, 1 = drive
- mdio_i  in  1  MDIO input from the pad

## Operation
- **MDC divider:** counter `cnt` runs 0..CLK_DIV-1 continuously after reset and wraps.
  - `tick` is asserted when `cnt==CLK_DIV-1`. `mdc` toggles on every tick.
  - A falling tick is a tick where `mdc` goes 1→0. A rising tick is a tick where `mdc` goes 0→1.
  - One bit period is 2·CLK_DIV clk cycles.
- **Drive and sample points:** all `mdio_o`/`mdio_oe` updates and all state transitions happen only on falling ticks. `mdio_i` is sampled on rising ticks.
- **States:** IDLE → PRE → FRAME → END → IDLE.
  - **IDLE:** `oe=0`, `mdio_o=1`, `busy=0`. On a falling tick with any `req` asserted:
    - arbitrate and latch the winner's op, phy, reg and wdat;
    - pulse `gnt[winner]` for that cycle and set `busy=1`;
    - go to PRE, or directly to FRAME if PRE_LEN=0.
  - **PRE:** `oe=1`, `mdio_o=1` for PRE_LEN bit periods, counted by a 6-bit counter.
  - **FRAME:** 32 bit periods, MSB first. The bit sequence is ST=01, OP (write 01, read 10), PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
    - Write: TA=10 is driven and DATA=wdat is driven; `oe=1` throughout.
    - Read: `oe` drops at the first TA bit and stays 0 through DATA. DATA bits are sampled on the rising tick in the middle of each bit into a 16-bit shift register, MSB first.
  - **END:** one bit period with `oe=0`. At the closing falling tick:
    - pulse `done`;
    - set `done_id` to the owner;
    - load `rdata` from the shift register for reads (`rdata` is unchanged on writes);
    - return to IDLE and clear `busy`.
    - A new grant can occur at the same falling tick only if `req` is already asserted; otherwise at a later falling tick.
- **Arbitration:**
  - Round-robin pointer `ptr`, reset to 0.
  - Only one request pending: that requester wins.
  - Both requests pending: `ptr` wins.
  - After every grant, `ptr` is set to the non-winner.
- **Request rules:** a requester holds `req` and its command stable until it sees its `gnt` pulse, then deasserts. A `req` still high after its `done` is a new request. Command inputs are ignored outside the grant cycle.
- **Reset mid-frame:** the frame is abandoned immediately. All state and counters clear, no `done` is issued, and the bus is released (`oe=0`).

## Timing
- Reset values: `mdc=0`, `mdio_o=1`, `mdio_oe=0`, `gnt=0`, `done=0`, `done_id=0`, `rdata=0`, `busy=0`, `cnt=0`, `ptr=0`.
- Grant to `done` = (PRE_LEN + 32 + 1)·2·CLK_DIV clk cycles exactly, for both write and read.
- `req` to `gnt` = 1 to 2·CLK_DIV clk cycles, waiting for the next falling tick.
- `rdata` is updated in the same cycle that `done` is asserted.
- TA on read: the master releases the bus at the start of the first TA bit. No contention check is made on the PHY's TA bit.

## Test plan
- **Write:** CLK_DIV=2, PRE_LEN=32, req0 write, phy=5'h01, reg=5'h00, wdat=16'h1140.
  - Sampling `mdio_o` on rising ticks gives 32×'1' then 0101_00001_00000_10_0001000101000000.
  - `oe=1` for 64 bits; `done` arrives 260 clk after `gnt`; `done_id=0`.
- **Read:** req1 read, phy=3, reg=2; a PHY model drives 16'hA5C3 after TA.
  - `oe=0` from the first TA bit; `rdata=16'hA5C3`; `done_id=1`.
- **Contention:** req0 and req1 both held from reset.
  - Grants alternate gnt=01, 10, 01, 10; no two frames overlap; `done_id` sequence is 0,1,0,1.
- **Preamble suppression:** PRE_LEN=0, write.
  - The first driven bits are 01; `done` arrives 132 clk after `gnt` with CLK_DIV=2.
- **Reset mid-read:** assert rst during DATA bit 8.
  - All outputs return to reset values within the same cycle; no `done`; a later request completes normally.
- **MDC:** with CLK_DIV=64, the `mdc` period measures 128 clk and the duty cycle is 50%. `mdio_o` changes only in cycles where `mdc` falls.
